// File: rtl/branch_resolver_pkg.sv
// Shared widths and opcode/func encodings for the ID-stage branch resolver.
package branch_resolver_pkg;

   localparam int unsigned BR_WORD_SIZE   = 16;
   localparam int unsigned BR_COUNT_WIDTH = 16;

   localparam logic [3:0] OP_BNE   = 4'd0;
   localparam logic [3:0] OP_BEQ   = 4'd1;
   localparam logic [3:0] OP_BGZ   = 4'd2;
   localparam logic [3:0] OP_BLZ   = 4'd3;
   localparam logic [3:0] OP_JMP   = 4'd9;
   localparam logic [3:0] OP_JAL   = 4'd10;
   localparam logic [3:0] OP_RTYPE = 4'd15;

   localparam logic [5:0] FUNC_JPR = 6'd25;
   localparam logic [5:0] FUNC_JRL = 6'd26;

endpackage

// File: rtl/branch_resolver_control_decoder.sv
// Combinational control-flow decode: classifies the ID instruction and
// computes its outcome and target from PC and forwarded operands.
module branch_resolver_control_decoder
   import branch_resolver_pkg::*;
#(
   parameter int unsigned WORD_SIZE = BR_WORD_SIZE
) (
   input  logic [WORD_SIZE-1:0] inst,
   input  logic [WORD_SIZE-1:0] pc,
   input  logic [WORD_SIZE-1:0] rs,
   input  logic [WORD_SIZE-1:0] rt,
   output logic                 is_control,
   output logic                 needs_regs,
   output logic                 taken,
   output logic                 is_link,
   output logic [WORD_SIZE-1:0] target
);

   logic [3:0]           op;
   logic [5:0]           func;
   logic [WORD_SIZE-1:0] pc_inc;
   logic [WORD_SIZE-1:0] br_target;
   logic [WORD_SIZE-1:0] abs_target;

   assign op         = inst[15:12];
   assign func       = inst[5:0];
   assign pc_inc     = pc + WORD_SIZE'(1);
   assign br_target  = pc_inc + {{(WORD_SIZE-8){inst[7]}}, inst[7:0]};
   assign abs_target = {pc[WORD_SIZE-1:12], inst[11:0]};

   always_comb begin
      is_control = 1'b0;
      needs_regs = 1'b0;
      taken      = 1'b0;
      is_link    = 1'b0;
      target     = pc_inc;
      case (op)
         OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
            is_control = 1'b1;
            needs_regs = 1'b1;
            target     = br_target;
            case (op)
               OP_BNE:  taken = (rs != rt);
               OP_BEQ:  taken = (rs == rt);
               OP_BGZ:  taken = ~rs[WORD_SIZE-1] & (|rs);
               default: taken = rs[WORD_SIZE-1];
            endcase
         end
         OP_JMP, OP_JAL: begin
            is_control = 1'b1;
            taken      = 1'b1;
            is_link    = (op == OP_JAL);
            target     = abs_target;
         end
         OP_RTYPE: begin
            if (func == FUNC_JPR || func == FUNC_JRL) begin
               is_control = 1'b1;
               needs_regs = 1'b1;
               taken      = 1'b1;
               is_link    = (func == FUNC_JRL);
               target     = rs;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolver: IF/ID latch, mispredict redirect, link write
// and saturating branch/miss statistics for the predictor update path.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int unsigned WORD_SIZE   = BR_WORD_SIZE,
   parameter int unsigned COUNT_WIDTH = BR_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   if_valid,
   input  logic [WORD_SIZE-1:0]   if_inst,
   input  logic [WORD_SIZE-1:0]   if_inst_addr,
   input  logic [WORD_SIZE-1:0]   if_pred_addr,
   input  logic [WORD_SIZE-1:0]   rs_data,
   input  logic [WORD_SIZE-1:0]   rt_data,
   input  logic                   operands_ready,
   output logic                   jump_decision,
   output logic [WORD_SIZE-1:0]   jump_target,
   output logic [WORD_SIZE-1:0]   next_addr_seq,
   output logic                   ID_nop,
   output logic                   resolve_stall,
   output logic                   redirect,
   output logic [WORD_SIZE-1:0]   redirect_addr,
   output logic                   link_write,
   output logic [WORD_SIZE-1:0]   link_addr,
   output logic [COUNT_WIDTH-1:0] branch_count,
   output logic [COUNT_WIDTH-1:0] miss_count
);

   logic                 id_valid;
   logic [WORD_SIZE-1:0] id_inst;
   logic [WORD_SIZE-1:0] id_pc;
   logic [WORD_SIZE-1:0] id_pred;

   logic                 is_control;
   logic                 needs_regs;
   logic                 taken;
   logic                 is_link;
   logic [WORD_SIZE-1:0] actual_next;
   logic                 adv;

   branch_resolver_control_decoder #(
      .WORD_SIZE (WORD_SIZE)
   ) u_decoder (
      .inst       (id_inst),
      .pc         (id_pc),
      .rs         (rs_data),
      .rt         (rt_data),
      .is_control (is_control),
      .needs_regs (needs_regs),
      .taken      (taken),
      .is_link    (is_link),
      .target     (jump_target)
   );

   // Resolution happens in the same cycle the instruction sits unblocked in ID.
   assign resolve_stall = id_valid & needs_regs & ~operands_ready;
   assign ID_nop        = ~id_valid | resolve_stall | stall;
   assign jump_decision = ~ID_nop & taken;
   assign next_addr_seq = id_pc + WORD_SIZE'(1);
   assign actual_next   = jump_decision ? jump_target : next_addr_seq;
   assign redirect      = ~ID_nop & (actual_next != id_pred);
   assign redirect_addr = actual_next;
   assign link_write    = ~ID_nop & is_link;
   assign link_addr     = next_addr_seq;
   assign adv           = ~stall & ~resolve_stall;

   // IF/ID latch; a redirect inserts one bubble and drops the wrong-path fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         id_valid <= 1'b0;
         id_inst  <= '0;
         id_pc    <= '0;
         id_pred  <= '0;
      end else if (adv) begin
         if (redirect) begin
            id_valid <= 1'b0;
         end else begin
            id_valid <= if_valid;
            id_inst  <= if_inst;
            id_pc    <= if_inst_addr;
            id_pred  <= if_pred_addr;
         end
      end
   end

   // Saturating statistics, counted only on resolving cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         branch_count <= '0;
         miss_count   <= '0;
      end else if (~ID_nop) begin
         if (is_control && !(&branch_count)) begin
            branch_count <= branch_count + COUNT_WIDTH'(1);
         end
         if (redirect && !(&miss_count)) begin
            miss_count <= miss_count + COUNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table, corner
// sequences, and random traffic against a behavioural pipeline model.
module tb_branch_resolver;

   localparam int unsigned W  = 16;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset, stall, if_valid, operands_ready;
   logic [W-1:0]  if_inst, if_inst_addr, if_pred_addr, rs_data, rt_data;
   logic          jump_decision, ID_nop, resolve_stall, redirect, link_write;
   logic [W-1:0]  jump_target, next_addr_seq, redirect_addr, link_addr;
   logic [CW-1:0] branch_count, miss_count;

   branch_resolver #(.WORD_SIZE(W), .COUNT_WIDTH(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_inst_addr   (if_inst_addr),
      .if_pred_addr   (if_pred_addr),
      .rs_data        (rs_data),
      .rt_data        (rt_data),
      .operands_ready (operands_ready),
      .jump_decision  (jump_decision),
      .jump_target    (jump_target),
      .next_addr_seq  (next_addr_seq),
      .ID_nop         (ID_nop),
      .resolve_stall  (resolve_stall),
      .redirect       (redirect),
      .redirect_addr  (redirect_addr),
      .link_write     (link_write),
      .link_addr      (link_addr),
      .branch_count   (branch_count),
      .miss_count     (miss_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model of what ID currently holds, plus the statistics.
   bit          m_valid;
   logic [15:0] m_inst, m_pc, m_pred;
   int          m_bc, m_mc;

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] pc;
      logic [15:0] pred;
      logic [15:0] rs;
      logic [15:0] rt;
      logic        jd;
      logic [15:0] tgt;
      logic        redir;
      logic        link;
   } vec_t;

   vec_t vecs[11];
   logic [15:0] pool[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void ref_eval(input logic [15:0] inst, input logic [15:0] pc,
                                    input logic [15:0] rs, input logic [15:0] rt,
                                    output bit ctl, output bit needs, output bit tk,
                                    output bit lnk, output logic [15:0] tgt);
      int op, fn, off, s_rs;
      op   = int'(inst[15:12]);
      fn   = int'(inst[5:0]);
      off  = int'($signed(inst[7:0]));
      s_rs = int'($signed(rs));
      ctl = 0; needs = 0; tk = 0; lnk = 0;
      tgt = 16'(int'(pc) + 1);
      if (op <= 3) begin
         ctl = 1; needs = 1;
         tgt = 16'(int'(pc) + 1 + off);
         case (op)
            0:       tk = (rs != rt);
            1:       tk = (rs == rt);
            2:       tk = (s_rs > 0);
            default: tk = (s_rs < 0);
         endcase
      end else if (op == 9 || op == 10) begin
         ctl = 1; tk = 1; lnk = (op == 10);
         tgt = (pc & 16'hF000) | (inst & 16'h0FFF);
      end else if (op == 15 && (fn == 25 || fn == 26)) begin
         ctl = 1; needs = 1; tk = 1; lnk = (fn == 26);
         tgt = rs;
      end
   endfunction

   // One clock: compare all outputs to the model, then advance the model.
   task automatic tick();
      bit ctl, needs, tk, lnk, nop, rstall, jd, redir;
      logic [15:0] tgt, seq, nxt;
      #2;
      ref_eval(m_inst, m_pc, rs_data, rt_data, ctl, needs, tk, lnk, tgt);
      seq    = m_pc + 16'd1;
      rstall = m_valid && needs && !operands_ready;
      nop    = !m_valid || rstall || stall;
      jd     = !nop && tk;
      nxt    = jd ? tgt : seq;
      redir  = !nop && (nxt != m_pred);
      chk("ID_nop", ID_nop, nop);
      chk("resolve_stall", resolve_stall, rstall);
      chk("jump_decision", jump_decision, jd);
      chk("redirect", redirect, redir);
      chk("next_addr_seq", next_addr_seq, seq);
      chk("link_write", link_write, !nop && lnk);
      chk("branch_count", branch_count, m_bc);
      chk("miss_count", miss_count, m_mc);
      if (redir) chk("redirect_addr", redirect_addr, nxt);
      if (!nop) chk("jump_target", jump_target, tgt);
      if (!nop && lnk) chk("link_addr", link_addr, seq);
      @(posedge clk);
      if (reset) begin
         m_valid = 0; m_inst = 0; m_pc = 0; m_pred = 0; m_bc = 0; m_mc = 0;
      end else begin
         if (!nop) begin
            if (ctl && m_bc < 65535) m_bc++;
            if (redir && m_mc < 65535) m_mc++;
         end
         if (!stall && !rstall) begin
            if (redir) m_valid = 0;
            else begin
               m_valid = if_valid; m_inst = if_inst; m_pc = if_inst_addr; m_pred = if_pred_addr;
            end
         end
      end
      #1;
   endtask

   task automatic load(input logic [15:0] inst, input logic [15:0] pc, input logic [15:0] pred);
      if_valid = 1; if_inst = inst; if_inst_addr = pc; if_pred_addr = pred;
      tick();
      if_valid = 0; if_inst = 16'h4000;
   endtask

   initial begin
      bit          c_ctl, c_needs, c_tk, c_lnk;
      logic [15:0] c_tgt;
      logic [3:0]  op;
      int          base;

      vecs[0]  = '{16'h1005, 16'h0010, 16'h0011, 16'd3,    16'd3, 1'b1, 16'h0016, 1'b1, 1'b0};
      vecs[1]  = '{16'h0005, 16'h0020, 16'h0021, 16'd7,    16'd7, 1'b0, 16'h0026, 1'b0, 1'b0};
      vecs[2]  = '{16'hA123, 16'h3FFF, 16'h3123, 16'd0,    16'd0, 1'b1, 16'h3123, 1'b0, 1'b1};
      vecs[3]  = '{16'h4000, 16'hFFFF, 16'h0000, 16'd0,    16'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{16'h2003, 16'h0100, 16'h0101, 16'h0005, 16'd0, 1'b1, 16'h0104, 1'b1, 1'b0};
      vecs[5]  = '{16'h2003, 16'h0100, 16'h0101, 16'h8000, 16'd0, 1'b0, 16'h0104, 1'b0, 1'b0};
      vecs[6]  = '{16'h30FE, 16'h0000, 16'hFFFF, 16'hFFFF, 16'd0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[7]  = '{16'hF019, 16'h0040, 16'h1234, 16'h1234, 16'd0, 1'b1, 16'h1234, 1'b0, 1'b0};
      vecs[8]  = '{16'h9ABC, 16'h5000, 16'h5ABC, 16'd0,    16'd0, 1'b1, 16'h5ABC, 1'b0, 1'b0};
      vecs[9]  = '{16'h5000, 16'h0200, 16'h0300, 16'd0,    16'd0, 1'b0, 16'h0201, 1'b1, 1'b0};
      vecs[10] = '{16'hF01A, 16'h0060, 16'h0061, 16'h0ABC, 16'd0, 1'b1, 16'h0ABC, 1'b1, 1'b1};
      pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h0002;
      pool[3] = 16'hFFFF; pool[4] = 16'h8000; pool[5] = 16'h7FFF;

      reset = 1; stall = 0; if_valid = 0; operands_ready = 1;
      if_inst = 0; if_inst_addr = 0; if_pred_addr = 0; rs_data = 0; rt_data = 0;
      @(posedge clk); #1;
      m_valid = 0; m_inst = 0; m_pc = 0; m_pred = 0; m_bc = 0; m_mc = 0;
      tick();
      reset = 0;

      // Directed vector table: load cycle, then the resolving cycle.
      for (int i = 0; i < 11; i++) begin
         load(vecs[i].inst, vecs[i].pc, vecs[i].pred);
         rs_data = vecs[i].rs; rt_data = vecs[i].rt;
         #1;
         if (i == 1) begin
            chk("beq branch_count", branch_count, 1);
            chk("beq miss_count", miss_count, 1);
         end
         chk("vec jump_decision", jump_decision, vecs[i].jd);
         chk("vec jump_target", jump_target, vecs[i].tgt);
         chk("vec redirect", redirect, vecs[i].redir);
         chk("vec link_write", link_write, vecs[i].link);
         chk("vec next_addr_seq", next_addr_seq, 16'(vecs[i].pc + 16'd1));
         if (vecs[i].redir) chk("vec redirect_addr", redirect_addr, vecs[i].tgt);
         if (vecs[i].link) chk("vec link_addr", link_addr, 16'(vecs[i].pc + 16'd1));
         tick();
         if (i == 0) begin
            #1;
            chk("beq bubble ID_nop", ID_nop, 1);
         end
      end

      // JPR waiting on operands, with a younger fetch presented meanwhile.
      load(16'hF019, 16'h0040, 16'h0041);
      if_valid = 1; if_inst = 16'h1000; if_inst_addr = 16'h0041; if_pred_addr = 16'h0042;
      operands_ready = 0; rs_data = 16'h0000;
      repeat (2) begin
         #1;
         chk("jpr resolve_stall", resolve_stall, 1);
         chk("jpr ID_nop", ID_nop, 1);
         tick();
      end
      operands_ready = 1; rs_data = 16'h1234;
      #1;
      chk("jpr redirect", redirect, 1);
      chk("jpr redirect_addr", redirect_addr, 16'h1234);
      tick();
      #1;
      chk("jpr discarded fetch", ID_nop, 1);
      if_valid = 0;
      tick();

      // Mispredicted BLZ held by an external stall resolves exactly once.
      load(16'h3004, 16'h0050, 16'h0051);
      rs_data = 16'h8000; stall = 1;
      base = m_mc;
      repeat (3) begin
         #1;
         chk("blz stalled redirect", redirect, 0);
         tick();
      end
      stall = 0;
      #1;
      chk("blz redirect", redirect, 1);
      chk("blz redirect_addr", redirect_addr, 16'h0055);
      tick();
      #1;
      chk("blz miss once", miss_count, base + 1);
      tick();
      chk("blz miss held", miss_count, base + 1);

      // Reset while a mispredict is resolving.
      load(16'h1005, 16'h0010, 16'h0011);
      rs_data = 16'd3; rt_data = 16'd3; reset = 1;
      tick();
      reset = 0;
      #1;
      chk("rst redirect", redirect, 0);
      chk("rst ID_nop", ID_nop, 1);
      chk("rst branch_count", branch_count, 0);
      chk("rst miss_count", miss_count, 0);
      tick();

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         reset          = ($urandom_range(0, 299) == 0);
         stall          = ($urandom_range(0, 3) == 0);
         operands_ready = ($urandom_range(0, 3) != 0);
         if_valid       = ($urandom_range(0, 4) != 0);
         case ($urandom_range(0, 9))
            0: op = 4'd0;  1: op = 4'd1;  2: op = 4'd2;  3: op = 4'd3;
            4: op = 4'd9;  5: op = 4'd10; 6, 7: op = 4'd15;
            8: op = 4'd4;  default: op = 4'd7;
         endcase
         if_inst = {op, 12'($urandom)};
         if (op == 4'd15 && $urandom_range(0, 3) != 0)
            if_inst[5:0] = ($urandom_range(0, 1) == 0) ? 6'd25 : 6'd26;
         if_inst_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                    : 16'($urandom);
         rs_data = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 5)];
         rt_data = pool[$urandom_range(0, 5)];
         ref_eval(if_inst, if_inst_addr, rs_data, rt_data, c_ctl, c_needs, c_tk, c_lnk, c_tgt);
         case ($urandom_range(0, 3))
            0, 1:    if_pred_addr = if_inst_addr + 16'd1;
            2:       if_pred_addr = c_tgt;
            default: if_pred_addr = 16'($urandom);
         endcase
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
